shared_stage_pipeline: RTL and testbench
========================================

# shared_stage_pipeline

Parametrised N-channel processing pipeline in which every channel passes through a chain of `DEPTH` register stages, and all channels share one resource at stage `SHARED_STAGE`. A round-robin arbiter grants the shared stage to one channel per cycle. Every losing channel freezes its entire pipeline (per-channel global stall) and back-pressures its producer. This block generalises the fixed two-pipeline wrapper between `producer_fsm` and `consumer_fsm` to arbitrary channel count, width and depth, and adds fair arbitration plus defined flush/stall interaction.

## Interface
- `NUM_CH`, 2: number of channels, ≥1.
- `WIDTH`, 32: data width per channel.
- `DEPTH`, 4: register stages per channel, ≥2.
- `SHARED_STAGE`, 2: index of the stage that uses the shared resource, 1..DEPTH-1.

One clock; reset is synchronous and active-high.

- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `in_data` input NUM_CH*WIDTH: channel c occupies bits [c*WIDTH +: WIDTH].
- `in_valid` input NUM_CH: per-channel input valid.
- `flush` input NUM_CH: per-channel flush, one-cycle pulse or level.
- `out_data` output NUM_CH*WIDTH: data from the last stage, same packing as `in_data`.
- `out_valid` output NUM_CH: per-channel output valid.
- `stall` output NUM_CH: per-channel stall to the producer, combinational.

## Operation
- Per channel c, per stage s: a `v[c][s]` valid bit and a `d[c][s]` data register.
- Data entering stage s is transformed:
  - s == SHARED_STAGE: x*3.
  - All other stages: x+1.
  - All arithmetic is modulo 2^WIDTH (truncate).
- Request: `req[c] = v[c][SHARED_STAGE-1] & ~flush[c]`. Bubbles never request.
- Arbiter:
  - Round-robin over `req`. At most one grant per cycle.
  - Priority starts at `ptr`. After a grant to channel g, `ptr` = (g+1) mod NUM_CH.
  - `ptr` is unchanged on cycles with no grant.
- `stall[c] = req[c] & ~gnt[c]`.
- Stalled channel: every `v`/`d` register of that channel holds, including stages downstream of the shared stage. `in_valid[c]` is ignored that cycle; the producer must hold its data.
- Non-stalled channel: all stages shift by one. Stage 0 loads `in_valid[c]`/`in_data[c]` transformed.
- `out_data[c] = d[c][DEPTH-1]`.
- `out_valid[c] = v[c][DEPTH-1] & ~stall[c]`. Each item is presented valid for exactly one cycle, with no duplicates.
- Flush of channel c:
  - Overrides stall.
  - Clears all `v[c][*]` at the next edge.
  - Discards the same-cycle `in_valid[c]`.
  - Forces `stall[c]`=0 and `out_valid[c]`=0 in that cycle.
  - Other channels are unaffected; a flushed channel's request is removed before arbitration, so the grant can go to another channel.
- Items within one channel leave in acceptance order. No loss, no duplication.

## Timing
- Reset values: all `v`=0, all `d`=0, `ptr`=0, `out_valid`=0, `out_data`=0, `stall`=0.
- Reset mid-operation discards all in-flight data at that edge. Reset has priority over flush and arbitration.
- Latency with no stall: an item accepted at edge T (`in_valid`=1, `stall`=0) appears with `out_valid`=1 during the cycle after edge T+DEPTH-1, i.e. DEPTH cycles.
- Each stall cycle adds one cycle of latency to every item in that channel.
- Throughput: with K channels continuously requesting, each channel receives 1 grant per K cycles.
- `stall` and `out_valid` are combinational from registers plus `flush`. No combinational path exists from `in_valid` or `in_data` to any output.

## Test plan
1. NUM_CH=2, DEPTH=4, SHARED_STAGE=2. Ch0 `in_data`=5 for one cycle, ch1 idle → `out_data[0]`=22 with `out_valid[0]`=1 exactly 4 cycles after acceptance; `stall` is never asserted.
2. Ch0=5 and ch1=10 accepted in the same cycle → ch0 is granted first (`ptr`=0) and `stall[1]`=1 for one cycle. Ch0 outputs 22 at +4 cycles; ch1 outputs 37 at +5 cycles, with no duplicate `out_valid`.
3. Both channels stream 0,1,2,… continuously → grants alternate 0,1,0,1. Each channel outputs (x+2)*3+1 in order at 1 item per 2 cycles, with no loss or duplication.
4. Ch1 is stalled with 3 items in flight and `flush[1]` is pulsed → `stall[1]`=0 that cycle and no further ch1 `out_valid`. The ch0 stream continues unchanged. A new ch1 item accepted after the flush emerges at +4 cycles.
5. Ch0 `in_data`=0xFFFFFFFF → `out_data[0]`=4 (wrap: 0, 1, 3, 4).
6. `reset` asserted for one cycle while both channels are full → the next cycle shows all `out_valid`=0, `stall`=0 and `ptr`=0. Simultaneous requests afterwards grant ch0 first.

Source files
------------

// File: rtl/shared_stage_pipeline.sv
// rtl/shared_stage_pipeline.sv - N-channel register pipeline sharing one round-robin arbitrated stage
// A losing channel freezes its whole pipeline; flush clears a channel and withdraws its request.
module shared_stage_pipeline #(
  parameter int NUM_CH       = 2,
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter int SHARED_STAGE = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH-1:0]       flush,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  output logic [NUM_CH-1:0]       stall
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DEPTH-1:0] vld_q [NUM_CH];
  logic [DEPTH-1:0] vld_d [NUM_CH];
  logic [WIDTH-1:0] dat_q [NUM_CH][DEPTH];
  logic [WIDTH-1:0] dat_d [NUM_CH][DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] gnt;
  int                arb_idx;
  logic              arb_found;

  // Round-robin search starting at ptr; a flushed channel never competes.
  always_comb begin
    req       = '0;
    gnt       = '0;
    ptr_d     = ptr_q;
    arb_idx   = 0;
    arb_found = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      req[c] = vld_q[c][SHARED_STAGE-1] & ~flush[c];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      arb_idx = int'(ptr_q) + i;
      if (arb_idx >= NUM_CH) begin
        arb_idx = arb_idx - NUM_CH;
      end
      if (!arb_found && req[arb_idx]) begin
        gnt[arb_idx] = 1'b1;
        arb_found    = 1'b1;
        ptr_d        = (arb_idx == NUM_CH - 1) ? '0 : PTR_W'(arb_idx + 1);
      end
    end
    stall = req & ~gnt;
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      vld_d[c] = vld_q[c];
      for (int s = 0; s < DEPTH; s++) begin
        dat_d[c][s] = dat_q[c][s];
      end
      if (!stall[c]) begin
        vld_d[c]    = {vld_q[c][DEPTH-2:0], in_valid[c]};
        dat_d[c][0] = in_data[c*WIDTH +: WIDTH] + WIDTH'(1);
        for (int s = 1; s < DEPTH; s++) begin
          dat_d[c][s] = (s == SHARED_STAGE) ? dat_q[c][s-1] * WIDTH'(3)
                                            : dat_q[c][s-1] + WIDTH'(1);
        end
      end
      // Flush wins over everything, including the same-cycle input.
      if (flush[c]) begin
        vld_d[c] = '0;
      end
    end
  end

  always_comb begin
    out_data  = '0;
    out_valid = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      out_data[c*WIDTH +: WIDTH] = dat_q[c][DEPTH-1];
      out_valid[c]               = vld_q[c][DEPTH-1] & ~stall[c] & ~flush[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        vld_q[c] <= '0;
        for (int s = 0; s < DEPTH; s++) begin
          dat_q[c][s] <= '0;
        end
      end
    end else begin
      ptr_q <= ptr_d;
      for (int c = 0; c < NUM_CH; c++) begin
        vld_q[c] <= vld_d[c];
        for (int s = 0; s < DEPTH; s++) begin
          dat_q[c][s] <= dat_d[c][s];
        end
      end
    end
  end

endmodule

// File: tb/tb_shared_stage_pipeline.sv
// tb/tb_shared_stage_pipeline.sv - self-checking bench for shared_stage_pipeline
// Directed vector table plus scoreboarded streaming, flush, latency and reset sequences.
module tb_shared_stage_pipeline;

  localparam int NUM_CH       = 2;
  localparam int WIDTH        = 32;
  localparam int DEPTH        = 4;
  localparam int SHARED_STAGE = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       flush;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       stall;

  always #5 clk = ~clk;

  shared_stage_pipeline #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .SHARED_STAGE(SHARED_STAGE)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .flush(flush), .out_data(out_data), .out_valid(out_valid), .stall(stall)
  );

  typedef struct packed {
    logic [1:0]  fl;
    logic [1:0]  iv;
    logic [31:0] id0;
    logic [31:0] id1;
    logic [1:0]  eov;
    logic [1:0]  est;
    logic [31:0] ed0;
    logic [31:0] ed1;
  } vec_t;

  vec_t        tv[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] nx0;
  logic [31:0] nx1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] xform(input logic [31:0] x);
    return (x + 32'd2) * 32'd3 + 32'd1;
  endfunction

  function automatic vec_t mk(input logic [1:0] fl, input logic [1:0] iv,
                              input logic [31:0] id0, input logic [31:0] id1,
                              input logic [1:0] eov, input logic [1:0] est,
                              input logic [31:0] ed0, input logic [31:0] ed1);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id0 = id0; v.id1 = id1;
    v.eov = eov; v.est = est; v.ed0 = ed0; v.ed1 = ed1;
    return v;
  endfunction

  task automatic pop_check(input int c, input logic [31:0] act);
    logic [31:0] e;
    if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
      n_checks++;
      n_err++;
      $display("FAIL sb_ch%0d: got out_valid with data 0x%0h expected no item", c, act);
    end else begin
      e = (c == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("sb_ch%0d", c), act, e);
    end
  endtask

  task automatic stream_cycle(input logic [1:0] on, input logic want_fl1, input logic rst,
                              output logic [1:0] ov_seen, output logic [1:0] st_seen,
                              output logic fl_done);
    @(negedge clk);
    reset    = rst;
    flush    = 2'b00;
    in_valid = on;
    in_data  = {nx1, nx0};
    #1;
    fl_done = 1'b0;
    if (want_fl1 && stall[1]) begin
      flush   = 2'b10;
      fl_done = 1'b1;
      #1;
    end
    ov_seen = out_valid;
    st_seen = stall;
    chk("one_grant", {31'd0, stall == 2'b11}, 32'd0);
    if (fl_done) begin
      chk("flush_stall1", {31'd0, stall[1]}, 32'd0);
      chk("flush_ov1", {31'd0, out_valid[1]}, 32'd0);
    end
    if (out_valid[0]) pop_check(0, out_data[31:0]);
    if (out_valid[1]) pop_check(1, out_data[63:32]);
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (flush[0]) q0.delete();
      else if (on[0] && !stall[0]) begin q0.push_back(xform(nx0)); nx0 = nx0 + 32'd1; end
      if (flush[1]) q1.delete();
      else if (on[1] && !stall[1]) begin q1.push_back(xform(nx1)); nx1 = nx1 + 32'd1; end
    end
  endtask

  initial begin
    logic [1:0] ov;
    logic [1:0] st;
    logic [1:0] prev_st;
    logic       fd;
    int         cnt0;
    int         cnt1;
    int         first_seen;

    reset = 1'b1; flush = '0; in_valid = '0; in_data = '0;
    nx0 = 32'd0; nx1 = 32'd100;
    prev_st = 2'b00; cnt0 = 0; cnt1 = 0; fd = 1'b0;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {30'd0, out_valid}, 32'd0);
    chk("rst_stall", {30'd0, stall}, 32'd0);
    chk("rst_out_data0", out_data[31:0], 32'd0);
    chk("rst_out_data1", out_data[63:32], 32'd0);

    // Both channels streaming: grants alternate, one item per channel every two cycles.
    for (int cyc = 0; cyc < 40; cyc++) begin
      stream_cycle(2'b11, 1'b0, 1'b0, ov, st, fd);
      if (cyc >= 4) begin
        chk("stream_one_stalled", {31'd0, (st == 2'b01) || (st == 2'b10)}, 32'd1);
        if (cyc >= 5) chk("stream_alternate", {31'd0, st != prev_st}, 32'd1);
      end
      prev_st = st;
      if (cyc >= 20) begin
        cnt0 += int'(ov[0]);
        cnt1 += int'(ov[1]);
      end
    end
    chk("throughput_ch0", 32'(cnt0), 32'd10);
    chk("throughput_ch1", 32'(cnt1), 32'd10);

    // Flush ch1 on a cycle where it is stalled with a full pipeline.
    fd = 1'b0;
    for (int i = 0; i < 6 && !fd; i++) begin
      stream_cycle(2'b11, q1.size() >= 3, 1'b0, ov, st, fd);
    end
    chk("flush_window", {31'd0, fd}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      stream_cycle(2'b01, 1'b0, 1'b0, ov, st, fd);
      chk("post_flush_ov1", {31'd0, ov[1]}, 32'd0);
      chk("post_flush_stall", {30'd0, st}, 32'd0);
    end
    for (int i = 0; i < 8; i++) stream_cycle(2'b00, 1'b0, 1'b0, ov, st, fd);
    chk("drain_ch0", 32'(q0.size()), 32'd0);
    chk("drain_ch1", 32'(q1.size()), 32'd0);

    // New ch1 item after the flush comes out DEPTH cycles after acceptance.
    stream_cycle(2'b10, 1'b0, 1'b0, ov, st, fd);
    first_seen = -1;
    for (int i = 1; i <= 6; i++) begin
      stream_cycle(2'b00, 1'b0, 1'b0, ov, st, fd);
      if (ov[1] && first_seen < 0) first_seen = i;
    end
    chk("latency_ch1", 32'(first_seen), 32'd4);

    // Fill both channels, then reset mid-stream; table row 0 checks the aftermath.
    for (int i = 0; i < 12; i++) stream_cycle(2'b11, 1'b0, 1'b0, ov, st, fd);
    stream_cycle(2'b11, 1'b0, 1'b1, ov, st, fd);

    //             fl     iv     id0           id1     eov    est    ed0    ed1
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b11, 32'd5,        32'd10, 2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b00, 2'b10, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b01, 2'b00, 32'd22, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b10, 2'b00, 32'd0, 32'd37));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b01, 32'd5,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b01, 2'b00, 32'd22, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b01, 32'hFFFFFFFF, 32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b01, 2'b00, 32'd4, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b01, 32'd9,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b01, 2'b01, 32'd50,       32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    for (int i = 0; i < 5; i++) begin
      tv.push_back(mk(2'b00, 2'b00, 32'd0,      32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    end
    tv.push_back(mk(2'b00, 2'b11, 32'd1,        32'd2,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b10, 2'b00, 32'd0,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b01, 2'b00, 32'd10, 32'd0));
    tv.push_back(mk(2'b00, 2'b00, 32'd0,        32'd0,  2'b00, 2'b00, 32'd0, 32'd0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      reset    = 1'b0;
      flush    = tv[i].fl;
      in_valid = tv[i].iv;
      in_data  = {tv[i].id1, tv[i].id0};
      #1;
      chk($sformatf("vec%0d_out_valid", i), {30'd0, out_valid}, {30'd0, tv[i].eov});
      chk($sformatf("vec%0d_stall", i), {30'd0, stall}, {30'd0, tv[i].est});
      if (tv[i].eov[0]) chk($sformatf("vec%0d_data0", i), out_data[31:0], tv[i].ed0);
      if (tv[i].eov[1]) chk($sformatf("vec%0d_data1", i), out_data[63:32], tv[i].ed1);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
